pipeline_run_ctrl: RTL and testbench

Run/halt/single-step controller for the 4-stage 8-bit pipelined processor. Sits beside the fetch stage and gates PC advance and IF/ID loading via `fetch_en`, injects bubbles while stopped, drains the pipeline before declaring halt, and optionally stops on a PC breakpoint. It also counts issued instructions for bring-up and debug.

---
 rtl/pipeline_run_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipeline_run_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl
// -----------------------------------------------------------------------------
// Run/halt/single-step controller for the 4-stage 8-bit pipelined processor.
// It sits beside the fetch stage. It gates PC advance and IF/ID loading with
// fetch_en, and it injects bubbles while the machine is stopped. After fetch
// stops it drains the pipeline for DRAIN_CYC cycles before it reports halt.
// It also counts issued instructions for bring-up and debug.
//
// Build option:
//   RUNCTRL_BP_EN  - when defined, adds the PC breakpoint compare, the sticky
//                    bp_hit flag and the first-RUN-cycle skip. When undefined,
//                    bp_en/bp_addr/pc_if are unused, bp_hit is tied to 0 and
//                    every output is decoded from registers only.
//
// Parameters:
//   PC_W       width of the fetch PC and breakpoint address
//   DRAIN_CYC  cycles needed to empty ID, EX and WB after fetch stops
//   CNT_W      width of the issued-instruction counter
//
// Ports:
//   Clk        clock, rising edge
//   Reset      synchronous active-high reset
//   run_req    pulse: start free-running fetch
//   halt_req   pulse: stop fetch and drain
//   step_req   pulse: issue one instruction, then drain
//   bp_en      breakpoint compare enable
//   bp_addr    breakpoint PC
//   pc_if      PC currently presented to instruction fetch
//   cnt_clr    synchronous clear of issue_cnt
//   fetch_en   1 = PC and IF/ID update this cycle
//   bubble     1 = IF/ID loads a NOP
//   state      current state (IDLE=00, RUN=01, DRAIN=10, STEP=11)
//   halted     1 = pipeline empty and stopped
//   bp_hit     sticky: last stop was caused by the breakpoint
//   issue_cnt  number of cycles with fetch_en=1, wraps
// -----------------------------------------------------------------------------
module pipeline_run_ctrl #(
    parameter int PC_W      = 8,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc_if,
    input  logic             cnt_clr,
    output logic             fetch_en,
    output logic             bubble,
    output logic [1:0]       state,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] issue_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        STEP  = 2'b11
    } run_state_t;

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

    run_state_t    cur_state;
    logic [DW-1:0] drain_cnt;

    // Registered versions of fetch_en/bubble, set together with the state so
    // they always match the state being entered.
    logic          fetch_reg;
    logic          bubble_reg;

    // High in a RUN cycle in which the breakpoint suppresses the fetch.
    logic          bp_stop;

`ifdef RUNCTRL_BP_EN
    // Marks the first RUN cycle after IDLE. A match there is ignored so that
    // resuming from a breakpoint issues the instruction at bp_addr.
    logic          first_run;

    assign bp_stop = (cur_state == RUN) && !first_run && bp_en && (pc_if == bp_addr);
`else
    logic          unused_bp_inputs;

    assign unused_bp_inputs = ^{bp_en, bp_addr, pc_if};
    assign bp_stop          = 1'b0;
    assign bp_hit           = 1'b0;
`endif

    assign state    = cur_state;
    assign fetch_en = fetch_reg & ~bp_stop;
    assign bubble   = bubble_reg | bp_stop;

    // Main controller FSM. Each transition also loads the registered outputs
    // for the state being entered. Requests are only acted upon in IDLE (run,
    // step) and RUN (halt). DRAIN and STEP drop all requests, so a pulse that
    // arrives there is lost and is not queued.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cur_state  <= IDLE;
            drain_cnt  <= '0;
            fetch_reg  <= 1'b0;
            bubble_reg <= 1'b1;
            halted     <= 1'b1;
`ifdef RUNCTRL_BP_EN
            bp_hit     <= 1'b0;
            first_run  <= 1'b0;
`endif
        end else begin
            case (cur_state)
                IDLE: begin
                    if (run_req || step_req) begin
                        cur_state  <= run_req ? RUN : STEP;
                        fetch_reg  <= 1'b1;
                        bubble_reg <= 1'b0;
                        halted     <= 1'b0;
`ifdef RUNCTRL_BP_EN
                        bp_hit     <= 1'b0;
                        first_run  <= run_req;
`endif
                    end
                end

                RUN: begin
`ifdef RUNCTRL_BP_EN
                    first_run <= 1'b0;
                    if (bp_stop) begin
                        bp_hit <= 1'b1;
                    end
`endif
                    if (bp_stop || halt_req) begin
                        cur_state  <= DRAIN;
                        drain_cnt  <= DRAIN_LOAD;
                        fetch_reg  <= 1'b0;
                        bubble_reg <= 1'b1;
                    end
                end

                STEP: begin
                    cur_state  <= DRAIN;
                    drain_cnt  <= DRAIN_LOAD;
                    fetch_reg  <= 1'b0;
                    bubble_reg <= 1'b1;
                end

                DRAIN: begin
                    if (drain_cnt == '0) begin
                        cur_state <= IDLE;
                        halted    <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end

                default: begin
                    cur_state  <= IDLE;
                    fetch_reg  <= 1'b0;
                    bubble_reg <= 1'b1;
                    halted     <= 1'b1;
                end
            endcase
        end
    end

    // Issued-instruction counter. It counts the final fetch_en, so a cycle
    // cancelled by the breakpoint is not counted. A clear wins over an
    // increment in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset || cnt_clr) begin
            issue_cnt <= '0;
        end else if (fetch_en) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb_pipeline_run_ctrl
// -----------------------------------------------------------------------------
// Directed self-checking bench for pipeline_run_ctrl with default parameters.
// Each step drives requests, then checks the outputs against hand-computed
// values. Breakpoint expectations depend on RUNCTRL_BP_EN.
// -----------------------------------------------------------------------------
module tb_pipeline_run_ctrl;

    logic        Clk;
    logic        Reset;
    logic        run_req;
    logic        halt_req;
    logic        step_req;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic [7:0]  pc_if;
    logic        cnt_clr;
    logic        fetch_en;
    logic        bubble;
    logic [1:0]  state;
    logic        halted;
    logic        bp_hit;
    logic [15:0] issue_cnt;

    logic        pc_rst;
    int          assert_count;
    int          fail_count;

    pipeline_run_ctrl dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .run_req   (run_req),
        .halt_req  (halt_req),
        .step_req  (step_req),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc_if     (pc_if),
        .cnt_clr   (cnt_clr),
        .fetch_en  (fetch_en),
        .bubble    (bubble),
        .state     (state),
        .halted    (halted),
        .bp_hit    (bp_hit),
        .issue_cnt (issue_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Stand-in for the fetch stage PC: advances only on cycles that fetch.
    always @(posedge Clk) begin
        if (pc_rst) begin
            pc_if <= 8'h00;
        end else if (fetch_en) begin
            pc_if <= pc_if + 8'h01;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic run, input logic halt, input logic step);
        run_req  = run;
        halt_req = halt;
        step_req = step;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearCount();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    // Halt pulse in a RUN cycle followed by the three drain cycles.
    task automatic haltAndDrain();
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        Reset        = 1'b1;
        pc_rst       = 1'b1;
        cnt_clr      = 1'b0;
        bp_en        = 1'b0;
        bp_addr      = 8'h00;
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Reset held for two cycles, then ten idle cycles.
        tick();
        tick();
        checkOutput("rst_state", {30'd0, state}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd1);
        Reset  = 1'b0;
        pc_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("idle_state", {30'd0, state}, 32'd0);
            checkOutput("idle_halted", {31'd0, halted}, 32'd1);
            checkOutput("idle_bubble", {31'd0, bubble}, 32'd1);
            checkOutput("idle_fetch", {31'd0, fetch_en}, 32'd0);
            checkOutput("idle_cnt", {16'd0, issue_cnt}, 32'd0);
            checkOutput("idle_bphit", {31'd0, bp_hit}, 32'd0);
        end

        // Run for 5 cycles, then a halt pulse whose own fetch still counts.
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("run_state", {30'd0, state}, 32'd1);
        checkOutput("run_fetch", {31'd0, fetch_en}, 32'd1);
        checkOutput("run_bubble", {31'd0, bubble}, 32'd0);
        repeat (5) tick();
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("halt_state_drain", {30'd0, state}, 32'd2);
        checkOutput("halt_cnt", {16'd0, issue_cnt}, 32'd6);
        checkOutput("halt_drain_fetch", {31'd0, fetch_en}, 32'd0);
        tick();
        tick();
        checkOutput("halt_not_yet", {31'd0, halted}, 32'd0);
        tick();
        checkOutput("halt_4cyc", {31'd0, halted}, 32'd1);
        checkOutput("halt_state_idle", {30'd0, state}, 32'd0);

        // Three single steps: STEP, 3x DRAIN, IDLE.
        clearCount();
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("step_state", {30'd0, state}, 32'd3);
            checkOutput("step_fetch", {31'd0, fetch_en}, 32'd1);
            for (int d = 0; d < 3; d++) begin
                tick();
                checkOutput("step_drain", {30'd0, state}, 32'd2);
            end
            tick();
            checkOutput("step_idle", {30'd0, state}, 32'd0);
            checkOutput("step_halted", {31'd0, halted}, 32'd1);
        end
        checkOutput("step_cnt", {16'd0, issue_cnt}, 32'd3);

        // run_req and step_req together: run wins.
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("runstep_state", {30'd0, state}, 32'd1);

        // run_req during DRAIN is dropped.
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("drain_run_ign", {30'd0, state}, 32'd2);
        tick();
        checkOutput("drain_run_ign2", {30'd0, state}, 32'd2);
        tick();
        checkOutput("drain_run_idle", {30'd0, state}, 32'd0);
        tick();
        checkOutput("drain_run_stay", {30'd0, state}, 32'd0);

        // Breakpoint at PC 05 with the PC counting from 0.
        pc_rst  = 1'b1;
        cnt_clr = 1'b1;
        tick();
        pc_rst  = 1'b0;
        cnt_clr = 1'b0;
        bp_en   = 1'b1;
        bp_addr = 8'h05;
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (5) tick();
`ifdef RUNCTRL_BP_EN
        checkOutput("bp_fetch_off", {31'd0, fetch_en}, 32'd0);
        checkOutput("bp_bubble_on", {31'd0, bubble}, 32'd1);
        checkOutput("bp_cnt", {16'd0, issue_cnt}, 32'd5);
        tick();
        checkOutput("bp_state_drain", {30'd0, state}, 32'd2);
        checkOutput("bp_hit_set", {31'd0, bp_hit}, 32'd1);
        repeat (3) tick();
        checkOutput("bp_idle", {30'd0, state}, 32'd0);
        checkOutput("bp_hit_sticky", {31'd0, bp_hit}, 32'd1);
        checkOutput("bp_cnt_hold", {16'd0, issue_cnt}, 32'd5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("bp_resume_fetch", {31'd0, fetch_en}, 32'd1);
        checkOutput("bp_hit_clr", {31'd0, bp_hit}, 32'd0);
        tick();
        checkOutput("bp_resume_cnt", {16'd0, issue_cnt}, 32'd6);
        haltAndDrain();
        checkOutput("bp_resume_idle", {30'd0, state}, 32'd0);

        // Halt pulse coinciding with a match at PC 0A: match wins.
        clearCount();
        bp_addr = 8'h0A;
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        applyStimulus(1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("bphalt_fetch_off", {31'd0, fetch_en}, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("bphalt_state", {30'd0, state}, 32'd2);
        checkOutput("bphalt_hit", {31'd0, bp_hit}, 32'd1);
        checkOutput("bphalt_cnt", {16'd0, issue_cnt}, 32'd3);
        repeat (3) tick();
        checkOutput("bphalt_idle", {30'd0, state}, 32'd0);
`else
        checkOutput("nobp_fetch_on", {31'd0, fetch_en}, 32'd1);
        checkOutput("nobp_state_run", {30'd0, state}, 32'd1);
        checkOutput("nobp_hit", {31'd0, bp_hit}, 32'd0);
        haltAndDrain();
        checkOutput("nobp_cnt", {16'd0, issue_cnt}, 32'd6);
        checkOutput("nobp_idle", {30'd0, state}, 32'd0);
`endif
        bp_en = 1'b0;

        // cnt_clr beats an increment while fetching.
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        cnt_clr = 1'b1;
        checkOutput("clr_fetch_on", {31'd0, fetch_en}, 32'd1);
        tick();
        cnt_clr = 1'b0;
        checkOutput("clr_cnt_zero", {16'd0, issue_cnt}, 32'd0);
        tick();
        checkOutput("clr_cnt_one", {16'd0, issue_cnt}, 32'd1);

        // Reset in the second DRAIN cycle.
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("mid_drain_state", {30'd0, state}, 32'd2);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkOutput("rstd_state", {30'd0, state}, 32'd0);
        checkOutput("rstd_halted", {31'd0, halted}, 32'd1);
        checkOutput("rstd_fetch", {31'd0, fetch_en}, 32'd0);
        checkOutput("rstd_bubble", {31'd0, bubble}, 32'd1);
        checkOutput("rstd_cnt", {16'd0, issue_cnt}, 32'd0);
        checkOutput("rstd_bphit", {31'd0, bp_hit}, 32'd0);
        tick();
        checkOutput("rstd_stay_idle", {30'd0, state}, 32'd0);

        // 2^16+2 fetch cycles wrap the counter to 2.
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (65537) tick();
        haltAndDrain();
        checkOutput("wrap_cnt", {16'd0, issue_cnt}, 32'd2);
        checkOutput("wrap_idle", {30'd0, state}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
